// File: rtl/simon_game_ctrl_if.sv
// Panel/display bundle of the Simon controller: debounced inputs in, LED/score drivers out.
// Latency: none (wires only).
// Backpressure: none; tick and button inputs are one-cycle strobes.
// Ports: i_tick, i_start, i_fast, i_button[N_COLORS] (panel -> engine);
//        o_start_led, o_led[N_COLORS], o_player[PW], o_score[SW], o_game_over, o_win (engine -> display).
interface simon_game_ctrl_if #(
  parameter int N_COLORS  = 4,
  parameter int MAX_LEN   = 32,
  parameter int N_PLAYERS = 2
);
  localparam int SW = $clog2(MAX_LEN + 1);
  localparam int PW = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1;

  logic                i_tick;
  logic                i_start;
  logic                i_fast;
  logic [N_COLORS-1:0] i_button;
  logic                o_start_led;
  logic [N_COLORS-1:0] o_led;
  logic [PW-1:0]       o_player;
  logic [SW-1:0]       o_score;
  logic                o_game_over;
  logic                o_win;

  // slave = the game engine, master = the panel / display side
  modport slave  (input  i_tick, i_start, i_fast, i_button,
                  output o_start_led, o_led, o_player, o_score, o_game_over, o_win);
  modport master (output i_tick, i_start, i_fast, i_button,
                  input  o_start_led, o_led, o_player, o_score, o_game_over, o_win);
endinterface

// File: rtl/simon_game_ctrl.sv
// Simon game engine: sequence generation, playback, input checking and scoring for N colours / P players.
// Latency: outputs are Moore decodes of registered state; i_start=0 reaches IDLE one cycle later.
// Backpressure: none; playback and timeout advance only on i_tick, presses outside INPUT are dropped.
// Ports: i_clk, i_reset_n (async active-low), bus (slave side of simon_game_ctrl_if).
module simon_game_ctrl #(
  parameter int          N_COLORS      = 4,
  parameter int          MAX_LEN       = 32,
  parameter int          N_PLAYERS     = 2,
  parameter int          ON_TICKS      = 500,
  parameter int          OFF_TICKS     = 250,
  parameter int          TIMEOUT_TICKS = 3000,
  parameter logic [15:0] SEED          = 16'hACE1
) (
  input  logic           i_clk,
  input  logic           i_reset_n,
  simon_game_ctrl_if.slave bus
);
  localparam int CW       = $clog2(N_COLORS);
  localparam int SW       = $clog2(MAX_LEN + 1);
  localparam int PW       = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1;
  localparam int AW       = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  // Fast mode halves both phases; a phase is never shorter than one tick.
  localparam int ON_FAST  = (ON_TICKS / 2 > 0) ? ON_TICKS / 2 : 1;
  localparam int OFF_FAST = (OFF_TICKS / 2 > 0) ? OFF_TICKS / 2 : 1;
  localparam int TMAX_A   = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int TMAX     = (TIMEOUT_TICKS > TMAX_A) ? TIMEOUT_TICKS : TMAX_A;
  localparam int TW       = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_GEN, S_SHOW_ON, S_SHOW_OFF, S_INPUT, S_ROUND_OK, S_LOSE, S_WIN
  } state_e;

  state_e              state_q, state_d;
  logic [15:0]         lfsr_q;
  logic [SW-1:0]       len_q, len_d;
  logic [SW-1:0]       idx_q, idx_d;
  logic [PW-1:0]       player_q, player_d;
  logic [SW-1:0]       score_q, score_d;
  logic [TW-1:0]       cnt_q, cnt_d;
  logic [N_COLORS-1:0] echo_q, echo_d;
  logic                mem_we;
  logic [CW-1:0]       mem_q [MAX_LEN];

  logic [CW-1:0]       cur_col;
  logic [N_COLORS-1:0] cur_led;
  logic [TW-1:0]       cnt_inc;
  logic [SW-1:0]       idx_inc;
  logic [TW-1:0]       on_lim;
  logic [TW-1:0]       off_lim;
  logic                press;

  assign cur_col = mem_q[idx_q[AW-1:0]];
  assign cur_led = {{(N_COLORS-1){1'b0}}, 1'b1} << cur_col;
  assign cnt_inc = cnt_q + TW'(1);
  assign idx_inc = idx_q + SW'(1);
  assign on_lim  = bus.i_fast ? TW'(ON_FAST)  : TW'(ON_TICKS);
  assign off_lim = bus.i_fast ? TW'(OFF_FAST) : TW'(OFF_TICKS);
  assign press   = |bus.i_button;

  // State and datapath registers; the LFSR free-runs so the colour depends on when GEN is reached.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= S_IDLE;
      lfsr_q   <= SEED;
      len_q    <= '0;
      idx_q    <= '0;
      player_q <= '0;
      score_q  <= '0;
      cnt_q    <= '0;
      echo_q   <= '0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      len_q    <= len_d;
      idx_q    <= idx_d;
      player_q <= player_d;
      score_q  <= score_d;
      cnt_q    <= cnt_d;
      echo_q   <= echo_d;
    end
  end

  // Sequence store has no reset: only entries below len are ever read.
  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      mem_q[len_q[AW-1:0]] <= lfsr_q[CW-1:0];
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    idx_d    = idx_q;
    player_d = player_q;
    score_d  = score_q;
    cnt_d    = cnt_q;
    echo_d   = '0;
    mem_we   = 1'b0;
    if (!bus.i_start) begin
      // Everything freezes; score/player stay visible until the next start clears them.
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d  = S_GEN;
          len_d    = '0;
          idx_d    = '0;
          player_d = '0;
          score_d  = '0;
        end
        S_GEN: begin
          mem_we  = 1'b1;
          len_d   = len_q + SW'(1);
          idx_d   = '0;
          cnt_d   = '0;
          state_d = S_SHOW_ON;
        end
        S_SHOW_ON: begin
          if (bus.i_tick) begin
            if (cnt_inc == on_lim) begin
              cnt_d   = '0;
              state_d = S_SHOW_OFF;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
        S_SHOW_OFF: begin
          if (bus.i_tick) begin
            if (cnt_inc == off_lim) begin
              cnt_d = '0;
              if (idx_inc == len_q) begin
                idx_d   = '0;
                state_d = S_INPUT;
              end else begin
                idx_d   = idx_inc;
                state_d = S_SHOW_ON;
              end
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
        S_INPUT: begin
          if (press) begin
            // A press wins over a same-cycle tick. Multi-bit presses never equal a one-hot colour.
            echo_d = bus.i_button;
            if (bus.i_button != cur_led) begin
              state_d = S_LOSE;
            end else begin
              cnt_d = '0;
              idx_d = idx_inc;
              if (idx_inc == len_q) begin
                state_d = S_ROUND_OK;
              end
            end
          end else if (bus.i_tick) begin
            if (cnt_inc == TW'(TIMEOUT_TICKS)) begin
              state_d = S_LOSE;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
        S_ROUND_OK: begin
          score_d = len_q;
          if (len_q == SW'(MAX_LEN)) begin
            state_d = S_WIN;
          end else begin
            player_d = (player_q == PW'(N_PLAYERS - 1)) ? '0 : player_q + PW'(1);
            state_d  = S_GEN;
          end
        end
        default: begin
          state_d = state_q;  // LOSE / WIN hold until start drops
        end
      endcase
    end
  end

  // Moore outputs
  always_comb begin
    bus.o_start_led = (state_q != S_IDLE);
    bus.o_led       = (state_q == S_SHOW_ON) ? cur_led : echo_q;
    bus.o_player    = player_q;
    bus.o_score     = score_q;
    bus.o_game_over = (state_q == S_LOSE) || (state_q == S_WIN);
    bus.o_win       = (state_q == S_WIN);
  end
endmodule

// File: tb/tb_simon_game_ctrl.sv
module tb_simon_game_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  simon_game_ctrl_if #(.N_COLORS(4), .MAX_LEN(3), .N_PLAYERS(2)) bus ();

  simon_game_ctrl #(
    .N_COLORS(4), .MAX_LEN(3), .N_PLAYERS(2),
    .ON_TICKS(2), .OFF_TICKS(1), .TIMEOUT_TICKS(5), .SEED(16'hACE1)
  ) dut (
    .i_clk(clk),
    .i_reset_n(rst_n),
    .bus(bus)
  );

  // Reference LFSR: 16-bit Fibonacci, taps 16,14,13,11, stepping every clock out of reset.
  logic [15:0] lfsr_m;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_m <= 16'hACE1;
    else        lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
  end

  // Scoreboard: expected outputs tagged with the cycle they must appear in.
  // Vector layout: {start_led, led[3:0], player, score[1:0], game_over, win}
  typedef struct packed {
    int         tag;
    logic [9:0] v;
  } exp_t;
  exp_t  exp_q[$];
  string nm_q[$];

  logic [1:0] seq [3];

  function automatic logic [3:0] oh(input logic [1:0] c);
    logic [3:0] one;
    one = 4'b0001;
    return one << c;
  endfunction

  task automatic expect_o(input string nm, input logic sl, input logic [3:0] led, input logic pl,
                          input logic [1:0] sc, input logic go, input logic w);
    exp_t e;
    e.tag = cyc;
    e.v   = {sl, led, pl, sc, go, w};
    exp_q.push_back(e);
    nm_q.push_back(nm);
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  exp_t       me;
  string      mn;
  logic [9:0] got;
  always @(negedge clk) begin
    got = {bus.o_start_led, bus.o_led, bus.o_player, bus.o_score, bus.o_game_over, bus.o_win};
    while (exp_q.size() > 0 && exp_q[0].tag < cyc) begin
      me = exp_q.pop_front();
      mn = nm_q.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: expectation for cycle %0d never sampled (now %0d)", mn, me.tag, cyc);
    end
    if (exp_q.size() > 0 && exp_q[0].tag == cyc) begin
      me = exp_q.pop_front();
      mn = nm_q.pop_front();
      checks++;
      if (got !== me.v) begin
        errors++;
        $display("FAIL %s @cyc %0d: got {sl,led,pl,sc,go,win}=%b required %b", mn, cyc, got, me.v);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_step();
    bus.i_tick = 1'b1;
    step();
    bus.i_tick = 1'b0;
  endtask

  task automatic press(input logic [3:0] b);
    bus.i_button = b;
    step();
    bus.i_button = 4'b0;
  endtask

  task automatic start_game();
    bus.i_start = 1'b1;
    step();
  endtask

  task automatic end_game(input logic pl, input logic [1:0] sc);
    bus.i_start = 1'b0;
    step();
    expect_o("idle_after_game", 1'b0, 4'b0, pl, sc, 1'b0, 1'b0);
  endtask

  // Called in the GEN cycle; plays back a round of length L (ON=2, OFF=1 ticks).
  task automatic play_round(input int L, input logic pl, input logic [1:0] sc, input bit ign);
    logic [1:0] wc;
    seq[L-1] = lfsr_m[1:0];
    expect_o("gen", 1'b1, 4'b0, pl, sc, 1'b0, 1'b0);
    step();
    for (int k = 0; k < L; k++) begin
      expect_o("show_on", 1'b1, oh(seq[k]), pl, sc, 1'b0, 1'b0);
      if (ign && k == 0) begin
        wc = seq[0] + 2'd1;
        bus.i_button = oh(wc);
      end
      step();
      bus.i_button = 4'b0;
      expect_o("show_hold", 1'b1, oh(seq[k]), pl, sc, 1'b0, 1'b0);
      tick_step();
      expect_o("show_tick1", 1'b1, oh(seq[k]), pl, sc, 1'b0, 1'b0);
      tick_step();
      expect_o("show_off", 1'b1, 4'b0, pl, sc, 1'b0, 1'b0);
      tick_step();
    end
    expect_o("input_entry", 1'b1, 4'b0, pl, sc, 1'b0, 1'b0);
  endtask

  task automatic play_inputs(input int L, input logic pl, input logic [1:0] sc);
    for (int k = 0; k < L; k++) begin
      press(oh(seq[k]));
      expect_o((k == L - 1) ? "round_ok_echo" : "press_echo", 1'b1, oh(seq[k]), pl, sc, 1'b0, 1'b0);
    end
    step();  // ROUND_OK -> GEN or WIN
  endtask

  logic [1:0] wc_main;
  logic [3:0] mb;

  initial begin
    bus.i_tick   = 1'b0;
    bus.i_start  = 1'b0;
    bus.i_fast   = 1'b0;
    bus.i_button = 4'b0;

    // Reset state
    step();
    expect_o("reset", 1'b0, 4'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step();
    expect_o("idle", 1'b0, 4'b0, 1'b0, 2'd0, 1'b0, 1'b0);

    // Async reset in the middle of playback
    start_game();
    seq[0] = lfsr_m[1:0];
    expect_o("gen_first", 1'b1, 4'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    step();
    expect_o("show_first", 1'b1, oh(seq[0]), 1'b0, 2'd0, 1'b0, 1'b0);
    step();
    rst_n = 1'b0;
    bus.i_start = 1'b0;
    expect_o("reset_mid_show", 1'b0, 4'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    step();
    rst_n = 1'b1;
    step();
    expect_o("idle_after_reset", 1'b0, 4'b0, 1'b0, 2'd0, 1'b0, 1'b0);

    // Game 1: rounds 1-2 correct (with an ignored press during playback), wrong colour at idx 1 in round 3
    start_game();
    play_round(1, 1'b0, 2'd0, 1'b1);
    play_inputs(1, 1'b0, 2'd0);
    play_round(2, 1'b1, 2'd1, 1'b0);
    play_inputs(2, 1'b1, 2'd1);
    play_round(3, 1'b0, 2'd2, 1'b0);
    press(oh(seq[0]));
    expect_o("r3_press0", 1'b1, oh(seq[0]), 1'b0, 2'd2, 1'b0, 1'b0);
    wc_main = seq[1] + 2'd1;
    press(oh(wc_main));
    expect_o("lose_wrong", 1'b1, oh(wc_main), 1'b0, 2'd2, 1'b1, 1'b0);
    step();
    expect_o("lose_hold", 1'b1, 4'b0, 1'b0, 2'd2, 1'b1, 1'b0);
    press(oh(seq[2]));
    expect_o("lose_press_ignored", 1'b1, 4'b0, 1'b0, 2'd2, 1'b1, 1'b0);
    end_game(1'b0, 2'd2);

    // Game 2: two buttons at once (one of them correct) in round 2
    start_game();
    play_round(1, 1'b0, 2'd0, 1'b0);
    play_inputs(1, 1'b0, 2'd0);
    play_round(2, 1'b1, 2'd1, 1'b0);
    wc_main = seq[0] + 2'd1;
    mb = oh(seq[0]) | oh(wc_main);
    press(mb);
    expect_o("lose_multi", 1'b1, mb, 1'b1, 2'd1, 1'b1, 1'b0);
    end_game(1'b1, 2'd1);

    // Game 3: timeout of 5 ticks; a press coinciding with a tick restarts the count
    start_game();
    play_round(1, 1'b0, 2'd0, 1'b0);
    play_inputs(1, 1'b0, 2'd0);
    play_round(2, 1'b1, 2'd1, 1'b0);
    for (int t = 0; t < 4; t++) begin
      tick_step();
      expect_o("wait_tick", 1'b1, 4'b0, 1'b1, 2'd1, 1'b0, 1'b0);
    end
    bus.i_tick = 1'b1;
    press(oh(seq[0]));
    bus.i_tick = 1'b0;
    expect_o("press_on_tick", 1'b1, oh(seq[0]), 1'b1, 2'd1, 1'b0, 1'b0);
    for (int t = 0; t < 4; t++) begin
      tick_step();
      expect_o("wait_tick2", 1'b1, 4'b0, 1'b1, 2'd1, 1'b0, 1'b0);
    end
    tick_step();
    expect_o("lose_timeout", 1'b1, 4'b0, 1'b1, 2'd1, 1'b1, 1'b0);
    end_game(1'b1, 2'd1);

    // Game 4: complete all MAX_LEN=3 rounds -> WIN
    start_game();
    play_round(1, 1'b0, 2'd0, 1'b0);
    play_inputs(1, 1'b0, 2'd0);
    play_round(2, 1'b1, 2'd1, 1'b0);
    play_inputs(2, 1'b1, 2'd1);
    play_round(3, 1'b0, 2'd2, 1'b0);
    play_inputs(3, 1'b0, 2'd2);
    expect_o("win", 1'b1, 4'b0, 1'b0, 2'd3, 1'b1, 1'b1);
    step();
    expect_o("win_hold", 1'b1, 4'b0, 1'b0, 2'd3, 1'b1, 1'b1);
    end_game(1'b0, 2'd3);

    // Drain the scoreboard
    step();
    step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
